// File: rtl/bus_arb_pkg.sv
// Shared FSM state type and parameter defaults for the bus arbiter.
package bus_arb_pkg;

  localparam int unsigned DefNumMasters    = 4;
  localparam int unsigned DefMaxHoldCycles = 8;

  typedef enum logic [0:0] {
    StIdle,
    StGranted
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping at NUM_MASTERS-1.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DefNumMasters
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last,
  output logic [NUM_MASTERS-1:0]         pick,
  output logic [$clog2(NUM_MASTERS)-1:0] pick_id
);

  localparam int unsigned IdW = $clog2(NUM_MASTERS);

  logic           found;
  logic [IdW-1:0] cand;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    cand    = '0;
    // Offset 1..NUM_MASTERS so the last-granted master is considered last.
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IdW'((32'(last) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        pick_id    = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with mandatory idle turnaround between owners.
// Define ARB_TIMEOUT_EN to cap each tenure at MAX_HOLD_CYCLES cycles.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = DefNumMasters,
  parameter int unsigned MAX_HOLD_CYCLES = DefMaxHoldCycles
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           bus_busy,
  output logic                           timeout
);

  localparam int unsigned    IdW      = $clog2(NUM_MASTERS);
  localparam logic [IdW-1:0] LastInit = IdW'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD_CYCLES < 2 || MAX_HOLD_CYCLES > 255)
  begin : g_bad_params
    $error("bus_arbiter: parameter out of range");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic [IdW-1:0]         id_q, id_d, last_q, last_d, pick_id;
  logic                   owner_req, expire;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .pick   (pick),
    .pick_id(pick_id)
  );

  assign owner_req = req[id_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // Expire on the edge that would make the count reach the limit: exactly
  // MAX_HOLD_CYCLES granted cycles are visible.
  assign expire = owner_req && (hold_q == 8'(MAX_HOLD_CYCLES - 1));

  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == StIdle) begin
      hold_d = '0;
    end else begin
      if (hold_q != 8'(MAX_HOLD_CYCLES)) hold_d = hold_q + 8'd1;
      timeout_d = expire;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGranted;
          grant_d = pick;
          id_d    = pick_id;
          last_d  = pick_id;
        end
      end
      StGranted: begin
        if (!owner_req || expire) begin
          state_d = StIdle;
          grant_d = '0;
          id_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= LastInit;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign bus_busy = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: randomized masters against a cycle-level ownership model.
module tb_bus_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned MaxHold = 8;
  localparam int unsigned IdW     = $clog2(N);
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   grant;
  logic [IdW-1:0] grant_id;
  logic           bus_busy, timeout;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .MAX_HOLD_CYCLES(MaxHold)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .bus_busy(bus_busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   grant;
    logic [IdW-1:0] id;
    logic           busy;
    logic           tmo;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference model: who owns the bus, who owned it last, how long they have held it.
  int m_owner  = -1;
  int m_last   = N - 1;
  int m_tenure = 0;
  bit m_tmo    = 1'b0;

  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] sh;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c  = (m_last + k) % N;
        sh = r >> c;
        if (sh[0]) begin
          m_owner  = c;
          m_last   = c;
          m_tenure = 1;
          break;
        end
      end
    end else begin
      sh = r >> m_owner;
      if (!sh[0]) begin
        m_owner = -1;
      end else if (TimeoutEn && m_tenure == MaxHold) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end else begin
        m_tenure++;
      end
    end
  endfunction

  always @(posedge clk) begin
    obs_t e;
    if (!reset) begin
      m_owner  = -1;
      m_last   = N - 1;
      m_tenure = 0;
      m_tmo    = 1'b0;
    end else begin
      model_step(req);
    end
    e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.id    = (m_owner >= 0) ? IdW'(m_owner) : '0;
    e.busy  = (m_owner >= 0);
    e.tmo   = m_tmo;
    exp_q.push_back(e);
  end

  // Monitor: pops one expectation per cycle plus structural checks.
  bit log_en  = 1'b0;
  int tmo_cnt = 0;
  int seen_ids[$];

  initial begin : monitor
    obs_t         e, a;
    logic [N-1:0] prev;
    bit           ok;
    prev = '0;
    forever begin
      @(posedge clk);
      #2;
      a = {grant, grant_id, bus_busy, timeout};
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("cycle", a, e);
      end
      ok = $onehot0(grant) && ((grant == '0) ? (grant_id == '0) : (grant == N'(1 << grant_id)));
      check("onehot_id", ok, 1);
      ok = !(prev != '0 && grant != '0 && grant != prev);
      check("turnaround", ok, 1);
      if (log_en && prev == '0 && grant != '0) seen_ids.push_back(int'(grant_id));
      if (log_en && timeout) tmo_cnt++;
      prev = grant;
    end
  end

  // Master agents: request, hold for len granted cycles (or until preempted), then rest.
  logic [N-1:0] en = '0;
  int           len_fix[N];
  int           gap_fix = 1;
  bit           glitch_en = 1'b0;
  bit           busy_m[N];
  int           tcnt[N], len[N], gap[N];

  task automatic clear_agents();
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 1'b0;
      tcnt[i]   = 0;
      gap[i]    = 0;
      len[i]    = 1;
    end
  endtask

  function automatic int next_gap();
    return (gap_fix < 0) ? int'($urandom_range(0, 4)) : gap_fix;
  endfunction

  task automatic drive_agents();
    for (int i = 0; i < N; i++) begin
      if (!en[i]) begin
        req[i] = 1'b0;
      end else if (busy_m[i]) begin
        if (grant[i]) begin
          tcnt[i]++;
          if (tcnt[i] >= len[i]) begin
            req[i] = 1'b0; busy_m[i] = 1'b0; gap[i] = next_gap();
          end
        end else if (tcnt[i] > 0) begin
          req[i] = 1'b0; busy_m[i] = 1'b0; gap[i] = next_gap();
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
        // Short pulse while someone else owns the bus; must not be latched.
        req[i] = glitch_en && grant != '0 && !grant[i] && ($urandom_range(0, 5) == 0);
      end else begin
        busy_m[i] = 1'b1;
        tcnt[i]   = 0;
        len[i]    = (len_fix[i] > 0) ? len_fix[i] : int'($urandom_range(1, 12));
        req[i]    = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_agents();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    clear_agents();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_log();
    seen_ids.delete();
    tmo_cnt = 0;
    log_en  = 1'b1;
  endtask

  initial begin : stim
    int ord2[5];
    int waited;
    ord2 = '{0, 1, 2, 3, 0};
    clear_agents();
    for (int i = 0; i < N; i++) len_fix[i] = 0;

    // Idle bus after reset.
    do_reset();
    en = '0;
    run(5);

    // All masters request, each holds 3 cycles: strict rotation from master 0.
    do_reset();
    for (int i = 0; i < N; i++) len_fix[i] = 3;
    gap_fix = 1;
    en      = '1;
    start_log();
    run(30);
    log_en = 1'b0;
    for (int k = 0; k < 5; k++)
      check("rr_order", (k < seen_ids.size()) ? seen_ids[k] : -1, ord2[k]);

    // Lone requester on master 2.
    do_reset();
    en      = 4'b0100;
    gap_fix = 200;
    len_fix[2] = 4;
    start_log();
    run(10);
    log_en = 1'b0;
    check("lone_id", (seen_ids.size() > 0) ? seen_ids[0] : -1, 2);

    // Long holder on master 1 with master 3 waiting.
    do_reset();
    en = 4'b1010;
    len_fix[1] = 20;
    len_fix[3] = 3;
    start_log();
    run(40);
    log_en = 1'b0;
    check("long_first", (seen_ids.size() > 0) ? seen_ids[0] : -1, 1);
    check("long_next", (seen_ids.size() > 1) ? seen_ids[1] : -1, 3);
    check("timeout_pulses", tmo_cnt, TimeoutEn ? 1 : 0);

    // Asynchronous reset mid-tenure, then regrant after release.
    do_reset();
    en = 4'b0010;
    len_fix[1] = 50;
    waited = 0;
    while (grant != 4'b0010 && waited < 6) begin
      run(1);
      waited++;
    end
    check("pre_reset_grant", grant, 4'b0010);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", {grant, bus_busy}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0010;
    clear_agents();
    busy_m[1] = 1'b1;
    @(posedge clk);
    #2;
    check("regrant", grant, 4'b0010);
    run(3);

    // Randomized traffic with glitching idle masters.
    do_reset();
    for (int i = 0; i < N; i++) len_fix[i] = 0;
    gap_fix   = -1;
    glitch_en = 1'b1;
    en        = '1;
    run(600);
    en = '0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
